multi_tick_prescaler: RTL and testbench
=======================================

# multi_tick_prescaler

Multi-channel programmable tick generator: divides the system clock into NUM_CH independent one-cycle tick strobes, each with its own run-time divisor and enable. It is the parametrised successor of the fixed single-rate prescaler and feeds timer-driven FSMs (traffic-light phase timers, debouncers, blink generators) that need different or reconfigurable rates from one block. Divisor changes are glitch-free: they take effect only at a channel's terminal count.

## Interface
- NUM_CH, 4, number of independent tick channels (1..16)
- CNT_W, 32, counter and divisor width in bits
- RESET_DIV, 50_000_000, divisor loaded into every channel at reset (must fit CNT_W)
- CH_W, $clog2(NUM_CH) min 1, width of the channel select (localparam)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  NUM_CH  per-channel run enable
- cfg_valid  in  1  divisor write request
- cfg_ready  out  1  divisor write can be accepted
- cfg_ch  in  CH_W  target channel of write
- cfg_div  in  CNT_W  new divisor value
- tick  out  NUM_CH  one-cycle strobe per channel, registered
- sync_req  in  1  only with PRESCALER_SYNC_EN: realign all channels

## Operation
- Per channel: active divisor div_act, shadow div_sh, pending flag pend, counter cnt (CNT_W), tick register.
- Reset (async, rst_n low): cnt=0, tick=0, div_act=RESET_DIV, pend=0; cfg_ready=1 after release.
- Counting (en[i]=1, div_act≥1): if cnt==div_act-1 then cnt<=0, tick[i]<=1; else cnt<=cnt+1, tick[i]<=0.
- div_act==0: channel halted, cnt held 0, tick 0.
- div_act==1: tick held high every cycle while enabled.
- en[i]=0: cnt<=0, tick[i]<=0 next edge; re-enable restarts a full period.
- Config handshake: transfer when cfg_valid && cfg_ready. cfg_ready = ~pend[cfg_ch] (combinational on cfg_ch). Out-of-range cfg_ch (≥NUM_CH): cfg_ready=1, write accepted and discarded.
- On transfer: div_sh[ch]<=cfg_div, pend[ch]<=1.
- Apply pending (div_act<=div_sh, pend<=0) on the edge where: channel at terminal count, or en[i]=0, or div_act==0. Counter wraps to 0 on that same edge; new period starts from 0.
- Transfer and apply on the same edge for the same channel: apply uses the old div_sh; new write becomes pending.
- Channels fully independent; no cross-channel ordering.

## Timing
- tick[i] rises one cycle after the cycle where cnt==div_act-1; period exactly div_act cycles in steady state.
- From reset release with en high: first tick during cycle div_act (counting from cycle 0 = first edge after release).
- cfg_ready reflects pend with zero latency; drops the cycle after a transfer, returns the cycle after apply.
- Divisor write latency: ≤ div_act+1 cycles (worst case just after a wrap).
- Reset mid-period: all outputs 0 immediately (async), pending writes lost.
- Counter arithmetic unsigned CNT_W, never exceeds div_act-1; no overflow path.

## Configuration
- PRESCALER_SYNC_EN defined: sync_req port present. sync_req high on an edge: every channel cnt<=0, tick<=0, pending divisors applied; takes priority over terminal count and config apply. Next period of every enabled channel starts aligned.
- Not defined: no sync_req port, no realign logic; channels only align via reset or enable.

## Test plan
- Reset, NUM_CH=2, RESET_DIV=5, en=2'b11 -> tick[0],tick[1] high on cycles 5,10,15, single-cycle each.
- Write div=3 to ch0 mid-period (cnt=1) -> cfg_ready low until terminal; remaining 5-period completes, then ticks every 3 cycles; ch1 unchanged.
- Write div=0 to ch1, then div=4 -> ch1 halts after current period; second write applies next cycle (halted), ticks every 4 cycles.
- Toggle en[0] low for 2 cycles at cnt=3 -> tick[0] stays 0, restart gives next tick 5 cycles after en rises.
- Assert rst_n low mid-period with pending write -> tick=0 immediately; after release divisors = RESET_DIV, cfg_ready=1.
- PRESCALER_SYNC_EN: divisors 4 and 6 free-running out of phase, pulse sync_req -> both cnt=0, next ticks 4 and 6 cycles later.

Source files
------------

// File: rtl/multi_tick_prescaler.sv
// rtl/multi_tick_prescaler.sv - multi-channel programmable tick generator with glitch-free divisor updates (optional PRESCALER_SYNC_EN realign)
module multi_tick_prescaler #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 32,
    parameter int RESET_DIV = 50_000_000,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick
`ifdef PRESCALER_SYNC_EN
    ,
    input  logic              sync_req
`endif
);

    // Pending flags padded to the full select range so out-of-range channels read as "not pending".
    localparam int NUM_PAD = 1 << CH_W;

    logic [CNT_W-1:0]   cnt_q     [NUM_CH];
    logic [CNT_W-1:0]   cnt_d     [NUM_CH];
    logic [CNT_W-1:0]   div_act_q [NUM_CH];
    logic [CNT_W-1:0]   div_act_d [NUM_CH];
    logic [CNT_W-1:0]   div_sh_q  [NUM_CH];
    logic [CNT_W-1:0]   div_sh_d  [NUM_CH];
    logic [NUM_CH-1:0]  pend_q;
    logic [NUM_CH-1:0]  pend_d;
    logic [NUM_CH-1:0]  tick_q;
    logic [NUM_CH-1:0]  tick_d;
    logic [NUM_PAD-1:0] pend_pad;
    logic               cfg_xfer;
    logic               sync_hit;

    // Ready is combinational on the selected channel's pending flag.
    always_comb begin
        pend_pad  = NUM_PAD'(pend_q);
        cfg_ready = ~pend_pad[cfg_ch];
        cfg_xfer  = cfg_valid && cfg_ready;
    end

`ifdef PRESCALER_SYNC_EN
    assign sync_hit = sync_req;
`else
    assign sync_hit = 1'b0;
`endif

    // Per-channel counting, tick generation and shadow-divisor apply.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            logic halted;
            logic terminal;
            cnt_d[i]     = cnt_q[i];
            div_act_d[i] = div_act_q[i];
            div_sh_d[i]  = div_sh_q[i];
            pend_d[i]    = pend_q[i];
            tick_d[i]    = 1'b0;
            halted       = !en[i] || (div_act_q[i] == '0);
            terminal     = !halted && (cnt_q[i] == div_act_q[i] - CNT_W'(1));

            if (sync_hit || halted) begin
                cnt_d[i] = '0;
            end else if (terminal) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            // New divisor only lands at a period boundary so no short or long tick is produced.
            if (pend_q[i] && (sync_hit || halted || terminal)) begin
                div_act_d[i] = div_sh_q[i];
                pend_d[i]    = 1'b0;
            end

            if (cfg_xfer && (32'(cfg_ch) == i)) begin
                div_sh_d[i] = cfg_div;
                pend_d[i]   = 1'b1;
            end
        end
    end

    // State registers; reset drops pending writes and restores the reset divisor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= '0;
                div_act_q[i] <= CNT_W'(RESET_DIV);
                div_sh_q[i]  <= CNT_W'(RESET_DIV);
            end
            pend_q <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= cnt_d[i];
                div_act_q[i] <= div_act_d[i];
                div_sh_q[i]  <= div_sh_d[i];
            end
            pend_q <= pend_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: tb/tb_multi_tick_prescaler.sv
// tb/tb_multi_tick_prescaler.sv - scoreboard bench for multi_tick_prescaler
module tb_multi_tick_prescaler;

    localparam int NUM_CH    = 3;
    localparam int CNT_W     = 8;
    localparam int RESET_DIV = 5;
    localparam int CH_W      = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] en = 3'b011;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic [NUM_CH-1:0] tick;
`ifdef PRESCALER_SYNC_EN
    logic              sync_req = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q [NUM_CH][$];

    multi_tick_prescaler #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_DIV(RESET_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .tick(tick)
`ifdef PRESCALER_SYNC_EN
        , .sync_req(sync_req)
`endif
    );

    always #5 clk = ~clk;

    // Edge counter: edge 1 is the first rising edge after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic push_ticks(input int ch, input int first, input int step, input int last);
        for (int t = first; t <= last; t += step) exp_q[ch].push_back(t);
    endtask

    // Advance to edge target, popping the scoreboard whenever a tick appears.
    task automatic run_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                while (exp_q[ch].size() > 0 && exp_q[ch][0] < cyc) begin
                    checks++; failures++;
                    $display("FAIL missing_tick ch%0d: absent, required at cycle %0d", ch, exp_q[ch].pop_front());
                end
                if (tick[ch]) begin
                    checks++;
                    if (exp_q[ch].size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_tick ch%0d: seen at cycle %0d, none required", ch, cyc);
                    end else begin
                        int e;
                        e = exp_q[ch].pop_front();
                        if (e !== cyc) begin
                            failures++;
                            $display("FAIL tick_time ch%0d: seen at cycle %0d, required %0d", ch, cyc, e);
                        end
                    end
                end
            end
        end
    endtask

    task automatic drain_check(input string name);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checks++;
            if (exp_q[ch].size() !== 0) begin
                failures++;
                $display("FAIL %s_drain ch%0d: %0d ticks outstanding, required 0", name, ch, exp_q[ch].size());
                exp_q[ch].delete();
            end
        end
    endtask

    task automatic cfg_write(input int ch, input int div);
        cfg_ch  = CH_W'(ch);
        cfg_div = CNT_W'(div);
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL cfg_ready_pre ch%0d: got %b, required 1", ch, cfg_ready);
        end
        cfg_valid = 1'b1;
        run_to(cyc + 1);
        cfg_valid = 1'b0;
    endtask

    task automatic check_ready(input string name, input int ch, input logic exp);
        cfg_ch = CH_W'(ch);
        #1;
        checks++;
        if (cfg_ready !== exp) begin
            failures++;
            $display("FAIL %s: cfg_ready got %b, required %b", name, cfg_ready, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tick !== 3'b000) begin
            failures++;
            $display("FAIL reset_tick: got %b, required 000", tick);
        end
        check_ready("reset_ready", 0, 1'b1);
        check_ready("oor_ready", 3, 1'b1);
        rst_n = 1'b1;
        push_ticks(0, 5, 5, 15);
        push_ticks(1, 5, 5, 15);
        run_to(15);
        drain_check("reset");
    endtask

    task automatic test_div_change();
        run_to(16);
        push_ticks(0, 20, 3, 29);
        push_ticks(1, 20, 5, 30);
        cfg_write(0, 3);
        check_ready("div_ready_after_xfer", 0, 1'b0);
        run_to(19);
        check_ready("div_ready_before_apply", 0, 1'b0);
        run_to(20);
        check_ready("div_ready_after_apply", 0, 1'b1);
        run_to(30);
        drain_check("div_change");
    endtask

    task automatic test_halt();
        push_ticks(0, 32, 3, 50);
        push_ticks(1, 35, 1, 35);
        push_ticks(1, 41, 4, 49);
        cfg_write(1, 0);
        run_to(35);
        cfg_write(1, 4);
        check_ready("halt_ready_after_xfer", 1, 1'b0);
        run_to(37);
        check_ready("halt_ready_applied", 1, 1'b1);
        run_to(50);
        drain_check("halt");
    endtask

    task automatic test_enable();
        push_ticks(0, 53, 5, 63);
        push_ticks(0, 73, 5, 78);
        push_ticks(1, 53, 4, 77);
        cfg_write(0, 5);
        run_to(66);
        en[0] = 1'b0;
        run_to(68);
        en[0] = 1'b1;
        run_to(78);
        drain_check("enable");
    endtask

    task automatic test_reset_mid();
        cfg_write(0, 2);
        check_ready("mid_pending", 0, 1'b0);
        push_ticks(1, 81, 1, 81);
        run_to(81);
        rst_n = 1'b0;
        #1;
        checks++;
        if (tick !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset_tick: got %b, required 000", tick);
        end
        check_ready("mid_reset_ready", 0, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_ticks(0, 5, 5, 10);
        push_ticks(1, 5, 5, 10);
        run_to(10);
        drain_check("reset_mid");
    endtask

`ifdef PRESCALER_SYNC_EN
    task automatic test_sync();
        push_ticks(0, 15, 4, 23);
        push_ticks(0, 29, 4, 37);
        push_ticks(1, 15, 6, 21);
        push_ticks(1, 31, 6, 37);
        cfg_write(0, 4);
        cfg_write(1, 6);
        run_to(24);
        sync_req = 1'b1;
        run_to(25);
        sync_req = 1'b0;
        run_to(37);
        drain_check("sync");
    endtask
`endif

    initial begin
        test_reset();
        test_div_change();
        test_halt();
        test_enable();
        test_reset_mid();
`ifdef PRESCALER_SYNC_EN
        test_sync();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
